// File: rtl/burst_sched.sv
// Burst scheduler: applies a shadowed pulse configuration to the pulse
// generator, paces bursts at a fixed repetition interval, and enforces a
// fault lockout with protection asserted.
module burst_sched #(
    parameter int unsigned LOCKOUT_CYC = 32'd100_000_000,
    parameter int unsigned HOLD_PAD    = 4
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        enable,
    input  logic        cfg_load,
    input  logic [9:0]  cfg_period,
    input  logic [5:0]  cfg_num,
    input  logic [23:0] cfg_prf,
    input  logic        fault,
    output logic [9:0]  pulse_period,
    output logic [5:0]  pulse_num,
    output logic        burst_syn,
    output logic        protect_en,
    output logic        acq_start,
    output logic        busy,
    output logic        cfg_err,
    output logic [15:0] burst_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        BURST = 3'd2,
        GAP   = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [9:0]  r_sh_period;
    logic [5:0]  r_sh_num;
    logic [23:0] r_sh_prf;

    logic [15:0] r_hold;
    logic [23:0] r_ivl;
    logic [23:0] r_icnt;
    logic [31:0] r_lock;

    logic [9:0]  r_pulse_period;
    logic [5:0]  r_pulse_num;
    logic        r_burst_syn;
    logic        r_protect_en;
    logic        r_acq_start;
    logic        r_busy;
    logic        r_cfg_err;
    logic [15:0] r_burst_cnt;

    logic        w_sh_valid;
    logic [15:0] w_prod;
    logic [15:0] w_hold;
    logic [23:0] w_hold3;
    logic [23:0] w_ivl;
    logic        w_burst_done;

    assign w_sh_valid   = (r_sh_period >= 10'd2) && (r_sh_num != 6'd0);
    assign w_prod       = {6'd0, r_sh_period} * {10'd0, r_sh_num};
    assign w_hold       = w_prod + 16'(HOLD_PAD);
    assign w_hold3      = {8'd0, w_hold} + 24'd3;
    assign w_ivl        = (r_sh_prf > w_hold3) ? r_sh_prf : w_hold3;
    assign w_burst_done = (r_state == BURST) && (w_next == GAP);

    assign pulse_period = r_pulse_period;
    assign pulse_num    = r_pulse_num;
    assign burst_syn    = r_burst_syn;
    assign protect_en   = r_protect_en;
    assign acq_start    = r_acq_start;
    assign busy         = r_busy;
    assign cfg_err      = r_cfg_err;
    assign burst_cnt    = r_burst_cnt;

    // Shadow configuration capture on cfg_load.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sh_period <= 10'd20;
            r_sh_num    <= 6'd1;
            r_sh_prf    <= 24'd1000;
        end else if (cfg_load) begin
            r_sh_period <= cfg_period;
            r_sh_num    <= cfg_num;
            r_sh_prf    <= cfg_prf;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; fault overrides every other transition.
    always_comb begin
        w_next = r_state;
        if (fault) begin
            w_next = FAULT;
        end else begin
            case (r_state)
                IDLE:    if (enable && w_sh_valid) w_next = ARM;
                ARM:     w_next = BURST;
                BURST:   if (r_icnt == {8'd0, r_hold}) w_next = GAP;
                GAP:     if (r_icnt == r_ivl - 24'd1)
                             w_next = (enable && w_sh_valid) ? ARM : IDLE;
                FAULT:   if (r_lock == 32'd0) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Burst datapath. Applied config, hold and interval are latched on the
    // edge entering ARM from the shadow that qualified the transition, so they
    // are visible throughout ARM and a cfg_load during ARM only affects the
    // next burst. The interval counter reads 0 in the ARM cycle, making the
    // ARM-to-ARM spacing exactly ivl.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hold         <= '0;
            r_ivl          <= '0;
            r_icnt         <= '0;
            r_lock         <= '0;
            r_pulse_period <= 10'd20;
            r_pulse_num    <= 6'd1;
        end else begin
            if (w_next == ARM) begin
                r_hold         <= w_hold;
                r_ivl          <= w_ivl;
                r_pulse_period <= r_sh_period;
                r_pulse_num    <= r_sh_num;
                r_icnt         <= '0;
            end else if (r_state == ARM || r_state == BURST || r_state == GAP) begin
                r_icnt <= r_icnt + 24'd1;
            end else begin
                r_icnt <= '0;
            end

            if (fault) begin
                r_lock <= 32'(LOCKOUT_CYC - 1);
            end else if (r_state == FAULT && r_lock != 32'd0) begin
                r_lock <= r_lock - 32'd1;
            end
        end
    end

    // Registered outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_burst_syn  <= 1'b0;
            r_protect_en <= 1'b0;
            r_acq_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_burst_cnt  <= '0;
        end else begin
            r_burst_syn  <= (w_next == BURST);
            r_protect_en <= (w_next == FAULT);
            r_acq_start  <= w_burst_done;
            r_busy       <= (w_next != IDLE);
            r_cfg_err    <= !w_sh_valid;
            if (w_burst_done) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/burst_sched.md
BURST_SCHED -- requirements
Module: burst_sched

Interface
REQ-001 Parameter LOCKOUT_CYC, default 32'd100_000_000; fault lockout length in clk cycles.
REQ-002 Parameter HOLD_PAD, default 4; extra cycles added to burst_syn high time.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  level; 1 = run periodic bursts.
REQ-006 cfg_load  in  1  one-cycle strobe; captures cfg_period, cfg_num and cfg_prf into shadow registers.
REQ-007 cfg_period  in  10  requested pulse period in clk cycles.
REQ-008 cfg_num  in  6  requested pulses per burst.
REQ-009 cfg_prf  in  24  requested burst repetition interval in clk cycles.
REQ-010 fault  in  1  level; overcurrent/overtemperature flag.
REQ-011 pulse_period  out  10  applied pulse period to pulse generator.
REQ-012 pulse_num  out  6  applied pulse count to pulse generator.
REQ-013 burst_syn  out  1  burst sync to pulse generator.
REQ-014 protect_en  out  1  protection request to pulse generator.
REQ-015 acq_start  out  1  one-cycle strobe at burst end; starts echo acquisition.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 cfg_err  out  1  high while the shadow config is invalid.
REQ-018 burst_cnt  out  16  completed bursts; wraps 16'hFFFF -> 0.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 Shadow registers: cfg_load SHALL capture all three cfg fields on the same edge; shadow reset values are period 10'd20, num 6'd1, prf 24'd1000.
REQ-021 Shadow config SHALL be invalid when period < 2 or num == 0; cfg_err follows shadow validity with a 1-cycle delay.
REQ-022 States SHALL be IDLE, ARM, BURST, GAP and FAULT.
REQ-023 IDLE: burst_syn=0, protect_en=0; go to ARM when enable=1 and shadow valid, else stay in IDLE.
REQ-024 ARM (exactly 1 cycle) SHALL perform all of the following:
- copy shadow period/num to pulse_period/pulse_num;
- latch hold = period*num + HOLD_PAD (16-bit unsigned, no overflow possible);
- latch ivl = max(shadow prf, hold + 3);
- clear the interval counter;
- go to BURST.
REQ-025 Applied pulse_period/pulse_num SHALL change only in ARM; cfg_load in ARM or in any later state SHALL NOT affect the burst in progress.
REQ-026 BURST: burst_syn=1 for exactly hold cycles, then burst_syn=0 and go to GAP.
REQ-027 On the BURST->GAP transition, acq_start SHALL be 1 for one cycle and burst_cnt SHALL increment.
REQ-028 The interval counter SHALL run from ARM, so the ARM-to-ARM spacing is exactly ivl cycles.
REQ-029 GAP: when the interval counter reaches ivl-1, go to ARM if enable=1 and shadow valid, else go to IDLE.
REQ-030 enable deasserted in ARM, BURST or GAP SHALL NOT truncate the current burst or gap.
REQ-031 fault=1 in any state SHALL take priority over every other transition: next state FAULT, burst_syn=0 on the next edge, protect_en=1, acq_start suppressed, burst_cnt unchanged.
REQ-032 FAULT: protect_en=1; the lockout counter counts LOCKOUT_CYC cycles from the last cycle with fault=1 (fault=1 reloads it); at expiry go to IDLE and set protect_en=0.
REQ-033 protect_en SHALL remain asserted for at least LOCKOUT_CYC cycles after fault entry, independent of enable.
REQ-034 Any undefined state encoding SHALL go to IDLE with outputs at reset values.

Reset
REQ-035 RESET_N=0 SHALL immediately force state IDLE and clear all counters.
REQ-036 Reset output values: burst_syn=0, protect_en=0, acq_start=0, busy=0, cfg_err=0, burst_cnt=0, pulse_period=10'd20, pulse_num=6'd1; shadows take REQ-020 values.
REQ-037 Reset asserted mid-burst SHALL drop burst_syn asynchronously; after release, operation resumes from IDLE only.

Verification
REQ-038 Defaults, enable=1 -> ARM, then burst_syn high 24 cycles (20*1+4), acq_start at burst end, next ARM 1000 cycles after the first, burst_cnt=1 after first burst.
REQ-039 cfg_load period=100 num=10 prf=500 -> hold=1004, ivl=1007 (clamped); burst_syn high 1004 cycles, bursts spaced 1007 cycles.
REQ-040 cfg_load period=50 during BURST -> current burst keeps period 20; next ARM applies 50.
REQ-041 fault pulsed 1 cycle mid-BURST, LOCKOUT_CYC=64 -> burst_syn low next edge, no acq_start, protect_en high 64 cycles, then IDLE and restart if enable=1.
REQ-042 cfg_load num=0 in IDLE with enable=1 -> cfg_err=1, no ARM; cfg_load num=3 -> cfg_err=0, burst starts.
REQ-043 Force burst_cnt to 16'hFFFF, complete one burst -> burst_cnt=0.
